// File: rtl/registers_command_initiator_pkg.sv
// Shared definitions for the ASCII register-access protocol: character codes,
// initiator FSM states and register-width derived sizes.
package registers_command_initiator_pkg;

  localparam logic [7:0] ASCII_COLON    = 8'h3A;
  localparam logic [7:0] ASCII_NBR_BASE = 8'h30;
  localparam logic [7:0] ASCII_W        = 8'h57;
  localparam logic [7:0] ASCII_R        = 8'h52;
  localparam logic [7:0] ASCII_W_LOWER  = 8'h77;
  localparam logic [7:0] ASCII_R_LOWER  = 8'h72;

  // Wide enough for 8 data bytes plus saturation headroom for over-long replies
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_COLON = 3'd1,
    ST_TX_REG   = 3'd2,
    ST_TX_CMD   = 3'd3,
    ST_TX_DATA  = 3'd4,
    ST_WAIT_RSP = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  function automatic int unsigned bytes_of(input int unsigned reg_width);
    return reg_width / 32'd8;
  endfunction

endpackage

// File: rtl/registers_command_initiator_if.sv
// Command/response port, UDP payload AXI-Stream pair and frame addressing
// of the register command initiator, bundled as one interface.
interface registers_command_initiator_if #(
  parameter int unsigned REG_WIDTH = 32
);
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic                 i_cmd_write;
  logic [3:0]           i_cmd_reg;
  logic [REG_WIDTH-1:0] i_cmd_wdata;

  logic                 o_rsp_valid;
  logic                 o_rsp_error;
  logic [REG_WIDTH-1:0] o_rsp_data;

  logic [7:0]           o_tx_udp_payload_axis_tdata;
  logic                 o_tx_udp_payload_axis_tvalid;
  logic                 o_tx_udp_payload_axis_tlast;
  logic                 i_tx_udp_payload_axis_tready;

  logic [7:0]           i_rx_udp_payload_axis_tdata;
  logic                 i_rx_udp_payload_axis_tvalid;
  logic                 i_rx_udp_payload_axis_tlast;
  logic                 o_rx_udp_payload_axis_tready;

  logic [31:0]          o_dest_ip;
  logic [15:0]          o_dest_port;
  logic                 o_rx_drop;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_reg, i_cmd_wdata,
    output o_cmd_ready, o_rsp_valid, o_rsp_error, o_rsp_data,
    output o_tx_udp_payload_axis_tdata, o_tx_udp_payload_axis_tvalid, o_tx_udp_payload_axis_tlast,
    input  i_tx_udp_payload_axis_tready,
    input  i_rx_udp_payload_axis_tdata, i_rx_udp_payload_axis_tvalid, i_rx_udp_payload_axis_tlast,
    output o_rx_udp_payload_axis_tready,
    output o_dest_ip, o_dest_port, o_rx_drop
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_reg, i_cmd_wdata,
    input  o_cmd_ready, o_rsp_valid, o_rsp_error, o_rsp_data,
    input  o_tx_udp_payload_axis_tdata, o_tx_udp_payload_axis_tvalid, o_tx_udp_payload_axis_tlast,
    output i_tx_udp_payload_axis_tready,
    output i_rx_udp_payload_axis_tdata, i_rx_udp_payload_axis_tvalid, i_rx_udp_payload_axis_tlast,
    input  o_rx_udp_payload_axis_tready,
    input  o_dest_ip, o_dest_port, o_rx_drop
  );
endinterface

// File: rtl/registers_command_initiator_rsp_timeout_timer.sv
// Read-reply watchdog: loaded on entry to the wait state, counts down while
// waiting and flags expiry in the TIMEOUT_CYCLES-th waiting cycle.
module rsp_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count_r;

  // Down-counter; parks at zero once run out
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= W'(TIMEOUT_CYCLES);
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = dec && (count_r == W'(1));

endmodule

// File: rtl/registers_command_initiator.sv
// Host-side register command initiator: serialises one read/write command at a
// time into an ASCII UDP payload frame and collects the read reply.
module registers_command_initiator #(
  parameter int unsigned REGS_NUM       = 4,
  parameter int unsigned REG_WIDTH      = 32,
  parameter logic [31:0] DEST_IP        = {8'd192, 8'd168, 8'd1, 8'd128},
  parameter logic [15:0] DEST_PORT      = 16'd1234,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic                          i_clk,
  input logic                          i_rst,
  registers_command_initiator_if.master bus
);
  import registers_command_initiator_pkg::*;

  localparam int unsigned    BYTES    = bytes_of(REG_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_e               state_r;
  logic                 write_r;
  logic [3:0]           reg_r;
  logic [REG_WIDTH-1:0] shift_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 cmd_ready_r;
  logic                 rsp_valid_r;
  logic                 rsp_error_r;
  logic [REG_WIDTH-1:0] rsp_data_r;
  logic [7:0]           tx_tdata_r;
  logic                 tx_tvalid_r;
  logic                 tx_tlast_r;
  logic                 rx_tready_r;
  logic                 rx_drop_r;

  logic                 tx_hs_s;
  logic                 rx_hs_s;
  logic                 timer_load_s;
  logic                 timer_dec_s;
  logic                 timer_expired_s;
  logic [REG_WIDTH-1:0] rx_shifted_s;

  assign tx_hs_s      = tx_tvalid_r && bus.i_tx_udp_payload_axis_tready;
  assign rx_hs_s      = bus.i_rx_udp_payload_axis_tvalid && rx_tready_r;
  assign rx_shifted_s = (shift_r << 4'd8) | REG_WIDTH'(bus.i_rx_udp_payload_axis_tdata);

  // Timer is loaded in the same edge that moves the FSM into the wait state
  always_comb begin
    timer_load_s = 1'b0;
    timer_dec_s  = 1'b0;
    if ((state_r == ST_TX_CMD) && tx_hs_s && !write_r) begin
      timer_load_s = 1'b1;
    end else begin
      timer_load_s = 1'b0;
    end
    if (state_r == ST_WAIT_RSP) begin
      timer_dec_s = 1'b1;
    end else begin
      timer_dec_s = 1'b0;
    end
  end

  rsp_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rsp_timeout_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (timer_load_s),
    .dec     (timer_dec_s),
    .expired (timer_expired_s)
  );

  // Command FSM with all stream and response outputs registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      write_r     <= 1'b0;
      reg_r       <= 4'd0;
      shift_r     <= {REG_WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_error_r <= 1'b0;
      rsp_data_r  <= {REG_WIDTH{1'b0}};
      tx_tdata_r  <= 8'h00;
      tx_tvalid_r <= 1'b0;
      tx_tlast_r  <= 1'b0;
      rx_tready_r <= 1'b0;
      rx_drop_r   <= 1'b0;
    end else begin
      rx_tready_r <= 1'b1;
      rx_drop_r   <= rx_hs_s && (state_r != ST_WAIT_RSP);
      case (state_r)
        ST_IDLE: begin
          if (bus.i_cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            write_r     <= bus.i_cmd_write;
            reg_r       <= bus.i_cmd_reg;
            shift_r     <= bus.i_cmd_wdata;
            if (32'(bus.i_cmd_reg) >= REGS_NUM) begin
              state_r     <= ST_DONE;
              rsp_valid_r <= 1'b1;
              rsp_error_r <= 1'b1;
              rsp_data_r  <= {REG_WIDTH{1'b0}};
            end else begin
              state_r     <= ST_TX_COLON;
              tx_tvalid_r <= 1'b1;
              tx_tdata_r  <= ASCII_COLON;
              tx_tlast_r  <= 1'b0;
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_TX_COLON: begin
          if (tx_hs_s) begin
            state_r    <= ST_TX_REG;
            tx_tdata_r <= ASCII_NBR_BASE + {4'd0, reg_r};
          end else begin
            state_r <= ST_TX_COLON;
          end
        end
        ST_TX_REG: begin
          if (tx_hs_s) begin
            state_r    <= ST_TX_CMD;
            tx_tdata_r <= write_r ? ASCII_W : ASCII_R;
            tx_tlast_r <= !write_r;
          end else begin
            state_r <= ST_TX_REG;
          end
        end
        ST_TX_CMD: begin
          if (tx_hs_s && write_r) begin
            state_r    <= ST_TX_DATA;
            tx_tdata_r <= shift_r[REG_WIDTH-1 -: 8];
            tx_tlast_r <= (LAST_IDX == {CNT_W{1'b0}});
            shift_r    <= shift_r << 4'd8;
            cnt_r      <= {CNT_W{1'b0}};
          end else if (tx_hs_s) begin
            state_r     <= ST_WAIT_RSP;
            tx_tvalid_r <= 1'b0;
            tx_tlast_r  <= 1'b0;
            tx_tdata_r  <= 8'h00;
            shift_r     <= {REG_WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
          end else begin
            state_r <= ST_TX_CMD;
          end
        end
        ST_TX_DATA: begin
          if (tx_hs_s && (cnt_r == LAST_IDX)) begin
            state_r     <= ST_DONE;
            tx_tvalid_r <= 1'b0;
            tx_tlast_r  <= 1'b0;
            tx_tdata_r  <= 8'h00;
            rsp_valid_r <= 1'b1;
            rsp_error_r <= 1'b0;
            rsp_data_r  <= {REG_WIDTH{1'b0}};
          end else if (tx_hs_s) begin
            tx_tdata_r <= shift_r[REG_WIDTH-1 -: 8];
            tx_tlast_r <= ((cnt_r + CNT_W'(1)) == LAST_IDX);
            shift_r    <= shift_r << 4'd8;
            cnt_r      <= cnt_r + CNT_W'(1);
          end else begin
            state_r <= ST_TX_DATA;
          end
        end
        ST_WAIT_RSP: begin
          // A reply tlast landing in the expiry cycle takes priority over the timeout
          if (rx_hs_s) begin
            shift_r <= rx_shifted_s;
            cnt_r   <= (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_W'(1));
            if (bus.i_rx_udp_payload_axis_tlast) begin
              state_r     <= ST_DONE;
              rsp_valid_r <= 1'b1;
              if (cnt_r == LAST_IDX) begin
                rsp_error_r <= 1'b0;
                rsp_data_r  <= rx_shifted_s;
              end else begin
                rsp_error_r <= 1'b1;
                rsp_data_r  <= {REG_WIDTH{1'b0}};
              end
            end else begin
              state_r <= ST_WAIT_RSP;
            end
          end else if (timer_expired_s) begin
            state_r     <= ST_DONE;
            rsp_valid_r <= 1'b1;
            rsp_error_r <= 1'b1;
            rsp_data_r  <= {REG_WIDTH{1'b0}};
          end else begin
            state_r <= ST_WAIT_RSP;
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          rsp_error_r <= 1'b0;
          rsp_data_r  <= {REG_WIDTH{1'b0}};
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          tx_tvalid_r <= 1'b0;
          tx_tlast_r  <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_cmd_ready                  = cmd_ready_r;
  assign bus.o_rsp_valid                  = rsp_valid_r;
  assign bus.o_rsp_error                  = rsp_error_r;
  assign bus.o_rsp_data                   = rsp_data_r;
  assign bus.o_tx_udp_payload_axis_tdata  = tx_tdata_r;
  assign bus.o_tx_udp_payload_axis_tvalid = tx_tvalid_r;
  assign bus.o_tx_udp_payload_axis_tlast  = tx_tlast_r;
  assign bus.o_rx_udp_payload_axis_tready = rx_tready_r;
  assign bus.o_dest_ip                    = DEST_IP;
  assign bus.o_dest_port                  = DEST_PORT;
  assign bus.o_rx_drop                    = rx_drop_r;

endmodule

// File: tb/tb_registers_command_initiator.sv
// Directed testbench for registers_command_initiator: frame contents, reply
// assembly, timeout, invalid register and mid-frame reset behaviour.
module tb_registers_command_initiator;

  logic clk;
  logic rst;

  registers_command_initiator_if #(.REG_WIDTH(32)) bus ();

  registers_command_initiator #(
    .REGS_NUM       (4),
    .REG_WIDTH      (32),
    .DEST_IP        ({8'd192, 8'd168, 8'd1, 8'd128}),
    .DEST_PORT      (16'd1234),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [8:0]  txq[$];
  logic [8:0]  expq[$];
  logic        got_rsp;
  int          nrsp;
  int          rsp_cyc;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic        rsp_rdy_at;
  int          drops;
  int          ca;
  int          cw;
  int          ct;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes/responses seen this cycle, then check tx hold
  task automatic step();
    logic       pend;
    logic [7:0] d;
    logic       l;
    pend = bus.o_tx_udp_payload_axis_tvalid && !bus.i_tx_udp_payload_axis_tready;
    d    = bus.o_tx_udp_payload_axis_tdata;
    l    = bus.o_tx_udp_payload_axis_tlast;
    if (bus.o_tx_udp_payload_axis_tvalid && bus.i_tx_udp_payload_axis_tready)
      txq.push_back({bus.o_tx_udp_payload_axis_tlast, bus.o_tx_udp_payload_axis_tdata});
    if (bus.o_rsp_valid) begin
      nrsp++;
      if (!got_rsp) begin
        got_rsp    = 1'b1;
        rsp_cyc    = cyc;
        rsp_err    = bus.o_rsp_error;
        rsp_data   = bus.o_rsp_data;
        rsp_rdy_at = bus.o_cmd_ready;
      end
    end
    if (bus.o_rx_drop) drops++;
    @(posedge clk);
    #1;
    cyc++;
    if (pend && !rst) begin
      check("tx_hold_valid", 64'(bus.o_tx_udp_payload_axis_tvalid), 64'd1);
      check("tx_hold_data", 64'({bus.o_tx_udp_payload_axis_tlast, bus.o_tx_udp_payload_axis_tdata}), 64'({l, d}));
    end
  endtask

  task automatic clear_trackers();
    txq.delete();
    got_rsp = 1'b0;
    nrsp    = 0;
    drops   = 0;
  endtask

  task automatic issue(input logic wr, input logic [3:0] rg, input logic [31:0] wd);
    clear_trackers();
    check("cmd_ready_before_issue", 64'(bus.o_cmd_ready), 64'd1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = wr;
    bus.i_cmd_reg   = rg;
    bus.i_cmd_wdata = wd;
    step();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_wdata = 32'h0;
    ca = cyc;
  endtask

  task automatic wait_rsp(input int budget);
    for (int i = 0; i < budget && !got_rsp; i++) step();
    check("rsp_within_budget", 64'(got_rsp), 64'd1);
    step();
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, 64'(txq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < txq.size(); i++)
      check({tag, "_byte"}, 64'(txq[i]), 64'(expq[i]));
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic last);
    bus.i_rx_udp_payload_axis_tvalid = 1'b1;
    bus.i_rx_udp_payload_axis_tdata  = b;
    bus.i_rx_udp_payload_axis_tlast  = last;
    ct = cyc;
    step();
    bus.i_rx_udp_payload_axis_tvalid = 1'b0;
    bus.i_rx_udp_payload_axis_tlast  = 1'b0;
    bus.i_rx_udp_payload_axis_tdata  = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_reg   = 4'd0;
    bus.i_cmd_wdata = 32'h0;
    bus.i_tx_udp_payload_axis_tready = 1'b1;
    bus.i_rx_udp_payload_axis_tdata  = 8'h00;
    bus.i_rx_udp_payload_axis_tvalid = 1'b0;
    bus.i_rx_udp_payload_axis_tlast  = 1'b0;
    clear_trackers();

    // Reset state
    step(); step();
    check("rst_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
    check("rst_tx_tvalid", 64'(bus.o_tx_udp_payload_axis_tvalid), 64'd0);
    check("rst_tx_tdata", 64'(bus.o_tx_udp_payload_axis_tdata), 64'd0);
    check("rst_tx_tlast", 64'(bus.o_tx_udp_payload_axis_tlast), 64'd0);
    check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    check("rst_rx_tready", 64'(bus.o_rx_udp_payload_axis_tready), 64'd0);
    check("rst_rx_drop", 64'(bus.o_rx_drop), 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
    check("post_rst_rx_tready", 64'(bus.o_rx_udp_payload_axis_tready), 64'd1);
    check("dest_ip", 64'(bus.o_dest_ip), 64'h00000000C0A80180);
    check("dest_port", 64'(bus.o_dest_port), 64'd1234);

    // Write reg 2 = DEADBEEF with tready held high
    issue(1'b1, 4'd2, 32'hDEADBEEF);
    check("wr_first_tvalid", 64'(bus.o_tx_udp_payload_axis_tvalid), 64'd1);
    check("wr_first_tdata", 64'(bus.o_tx_udp_payload_axis_tdata), 64'h3A);
    check("wr_cmd_ready_low", 64'(bus.o_cmd_ready), 64'd0);
    wait_rsp(20);
    expq = '{9'h03A, 9'h032, 9'h057, 9'h0DE, 9'h0AD, 9'h0BE, 9'h1EF};
    check_frame("wr_frame");
    check("wr_rsp_latency", 64'(rsp_cyc - ca), 64'd7);
    check("wr_rsp_error", 64'(rsp_err), 64'd0);
    check("wr_rsp_data", 64'(rsp_data), 64'd0);
    check("wr_rsp_pulses", 64'(nrsp), 64'd1);
    check("wr_ready_during_rsp", 64'(rsp_rdy_at), 64'd0);
    check("wr_ready_after_rsp", 64'(bus.o_cmd_ready), 64'd1);

    // Read reg 1, well-formed 4-byte reply
    issue(1'b0, 4'd1, 32'h0);
    step(); step(); step();
    rx_byte(8'h12, 1'b0);
    rx_byte(8'h34, 1'b0);
    rx_byte(8'h56, 1'b0);
    rx_byte(8'h78, 1'b1);
    wait_rsp(10);
    expq = '{9'h03A, 9'h031, 9'h152};
    check_frame("rd_frame");
    check("rd_rsp_latency", 64'(rsp_cyc - ct), 64'd1);
    check("rd_rsp_error", 64'(rsp_err), 64'd0);
    check("rd_rsp_data", 64'(rsp_data), 64'h12345678);
    check("rd_drops", 64'(drops), 64'd0);

    // Write reg 0 under pseudo-random tready backpressure
    bus.i_tx_udp_payload_axis_tready = 1'b0;
    issue(1'b1, 4'd0, 32'h01020304);
    for (int i = 0; i < 200 && !got_rsp; i++) begin
      bus.i_tx_udp_payload_axis_tready = 1'($urandom_range(0, 1));
      step();
    end
    bus.i_tx_udp_payload_axis_tready = 1'b1;
    wait_rsp(5);
    expq = '{9'h03A, 9'h030, 9'h057, 9'h001, 9'h002, 9'h003, 9'h104};
    check_frame("bp_frame");
    check("bp_rsp_error", 64'(rsp_err), 64'd0);
    check("bp_rsp_pulses", 64'(nrsp), 64'd1);

    // Short reply of 3 bytes
    issue(1'b0, 4'd3, 32'h0);
    step(); step(); step();
    rx_byte(8'hAA, 1'b0);
    rx_byte(8'hBB, 1'b0);
    rx_byte(8'hCC, 1'b1);
    wait_rsp(10);
    check("short_rsp_error", 64'(rsp_err), 64'd1);
    check("short_rsp_data", 64'(rsp_data), 64'd0);

    // Long reply of 5 bytes
    issue(1'b0, 4'd0, 32'h0);
    step(); step(); step();
    rx_byte(8'h11, 1'b0);
    rx_byte(8'h22, 1'b0);
    rx_byte(8'h33, 1'b0);
    rx_byte(8'h44, 1'b0);
    rx_byte(8'h55, 1'b1);
    wait_rsp(10);
    check("long_rsp_error", 64'(rsp_err), 64'd1);
    check("long_rsp_data", 64'(rsp_data), 64'd0);

    // No reply: timeout after 100 waiting cycles, then a late byte is dropped
    issue(1'b0, 4'd2, 32'h0);
    step(); step(); step();
    cw = cyc;
    wait_rsp(150);
    expq = '{9'h03A, 9'h032, 9'h152};
    check_frame("to_frame");
    check("to_latency", 64'(rsp_cyc - cw), 64'd100);
    check("to_rsp_error", 64'(rsp_err), 64'd1);
    check("to_rsp_data", 64'(rsp_data), 64'd0);
    drops = 0;
    rx_byte(8'h99, 1'b1);
    step();
    check("late_byte_drop", 64'(drops), 64'd1);
    check("late_byte_no_rsp", 64'(nrsp), 64'd1);

    // Register index out of range
    issue(1'b0, 4'd4, 32'h0);
    wait_rsp(10);
    check("bad_reg_latency", 64'(rsp_cyc - ca), 64'd0);
    check("bad_reg_error", 64'(rsp_err), 64'd1);
    check("bad_reg_data", 64'(rsp_data), 64'd0);
    check("bad_reg_no_tx", 64'(txq.size()), 64'd0);

    // Reset in the middle of a write frame
    issue(1'b1, 4'd3, 32'hCAFEF00D);
    step(); step(); step();
    check("mid_tvalid_before_rst", 64'(bus.o_tx_udp_payload_axis_tvalid), 64'd1);
    rst = 1'b1;
    step();
    check("mid_rst_tvalid", 64'(bus.o_tx_udp_payload_axis_tvalid), 64'd0);
    check("mid_rst_tdata", 64'(bus.o_tx_udp_payload_axis_tdata), 64'd0);
    check("mid_rst_tlast", 64'(bus.o_tx_udp_payload_axis_tlast), 64'd0);
    check("mid_rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    check("mid_rst_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
    check("mid_rst_rx_tready", 64'(bus.o_rx_udp_payload_axis_tready), 64'd0);
    clear_trackers();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("mid_rst_no_rsp", 64'(nrsp), 64'd0);
    check("mid_rst_no_tx", 64'(txq.size()), 64'd0);
    check("mid_rst_ready_again", 64'(bus.o_cmd_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
